// File: rtl/ro_sweep_ctrl.sv
// ro_sweep_ctrl: steps a 16-tap ring oscillator through every tap select and stores
// a gated rising-edge count per tap. Optional min/max tracking: RO_SWEEP_MINMAX_EN.
module ro_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             static_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_in,
  output logic             select3,
  output logic             select2,
  output logic             select1,
  output logic             select0,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
`ifdef RO_SWEEP_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt,
  output logic [3:0]       min_sel,
  output logic [3:0]       max_sel
`endif
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_STORE, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_sel;
  logic [CNT_W-1:0]   r_bank [16];
  logic [CNT_W-1:0]   r_rd_data;
  logic               w_edge;
  logic               w_timer_zero;
  logic               w_store_wr;

  assign w_edge       = r_sync2 & ~r_prev;
  assign w_timer_zero = (r_timer == '0);
  assign w_store_wr   = (r_state == ST_STORE) && !abort;

  assign {select3, select2, select1, select0} = r_sel;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign rd_data = r_rd_data;

  always_ff @(posedge static_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge static_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // abort forces IDLE from every state; in IDLE it also blocks a simultaneous start
  always_comb begin
    w_state_nx = r_state;
    if (abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_state_nx = ST_SETTLE;
        ST_SETTLE:  if (w_timer_zero) w_state_nx = ST_MEASURE;
        ST_MEASURE: if (w_timer_zero) w_state_nx = ST_STORE;
        ST_STORE:   w_state_nx = (r_sel == 4'd15) ? ST_DONE : ST_SETTLE;
        ST_DONE:    w_state_nx = ST_IDLE;
        default:    w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge static_clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
    end else if (abort && r_state != ST_IDLE) begin
      r_sel <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_sel   <= '0;
            r_timer <= TMR_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (w_timer_zero) begin
            r_cnt   <= '0;
            r_timer <= TMR_W'(GATE_CYCLES - 1);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_edge && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (!w_timer_zero) r_timer <= r_timer - 1'b1;
        end
        ST_STORE: begin
          if (r_sel != 4'd15) begin
            r_sel   <= r_sel + 4'd1;
            r_timer <= TMR_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_DONE:  r_sel <= '0;
        default:  r_sel <= '0;
      endcase
    end
  end

  // Bank write and read share a block; the non-blocking write gives read-old-value.
  always_ff @(posedge static_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) r_bank[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_store_wr) r_bank[r_sel] <= r_cnt;
      r_rd_data <= r_bank[rd_addr];
    end
  end

`ifdef RO_SWEEP_MINMAX_EN
  logic [CNT_W-1:0] r_min_cnt;
  logic [CNT_W-1:0] r_max_cnt;
  logic [3:0]       r_min_sel;
  logic [3:0]       r_max_sel;

  // Every sweep begins at sel 0, so the sel-0 store is the unconditional first load.
  always_ff @(posedge static_clk or posedge rst) begin
    if (rst) begin
      r_min_cnt <= '0;
      r_max_cnt <= '0;
      r_min_sel <= '0;
      r_max_sel <= '0;
    end else if (w_store_wr) begin
      if (r_sel == 4'd0 || r_cnt < r_min_cnt) begin
        r_min_cnt <= r_cnt;
        r_min_sel <= r_sel;
      end
      if (r_sel == 4'd0 || r_cnt > r_max_cnt) begin
        r_max_cnt <= r_cnt;
        r_max_sel <= r_sel;
      end
    end
  end

  assign min_cnt = r_min_cnt;
  assign max_cnt = r_max_cnt;
  assign min_sel = r_min_sel;
  assign max_sel = r_max_sel;
`endif

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Self-checking bench for ro_sweep_ctrl: full sweep, saturation, abort, start filtering,
// reset mid-sweep, and min/max tracking when RO_SWEEP_MINMAX_EN is defined.
`timescale 1ns/1ps
module tb_ro_sweep_ctrl;

  localparam int unsigned S   = 4;
  localparam int unsigned G   = 100;
  localparam int unsigned GMM = 2000;
  localparam int SWEEP_LEN    = 16 * (S + G + 1) + 1;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        osc_main, osc_sat;
  logic [3:0]  rd_addr;
  logic [3:0]  m_sel, s_sel;
  logic        m_busy, m_done, s_busy, s_done;
  logic [15:0] m_rd;
  logic [3:0]  s_rd;
  int          osc_half_main;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int addr; int lo; int hi; int which;} exp_t;
  exp_t sb_q[$];
  int   exp_lo[16];
  int   exp_hi[16];
  int   sel_q[$];

  always #5 clk = ~clk;

  ro_sweep_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(16)) u_dut (
    .static_clk(clk), .rst(rst), .start(start), .abort(abort), .osc_in(osc_main),
    .select3(m_sel[3]), .select2(m_sel[2]), .select1(m_sel[1]), .select0(m_sel[0]),
    .busy(m_busy), .done(m_done), .rd_addr(rd_addr), .rd_data(m_rd)
  );

  ro_sweep_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(4)) u_sat (
    .static_clk(clk), .rst(rst), .start(start), .abort(abort), .osc_in(osc_sat),
    .select3(s_sel[3]), .select2(s_sel[2]), .select1(s_sel[1]), .select0(s_sel[0]),
    .busy(s_busy), .done(s_done), .rd_addr(rd_addr), .rd_data(s_rd)
  );

  // Oscillator toggles sit 3 ns off the 5 ns clock grid, so no sample races an edge.
  initial begin
    osc_main = 1'b0;
    #3;
    forever begin #(osc_half_main); osc_main = ~osc_main; end
  end

  initial begin
    osc_sat = 1'b0;
    #3;
    forever begin #10; osc_sat = ~osc_sat; end
  end

`ifdef RO_SWEEP_MINMAX_EN
  logic        mm_start;
  logic        osc_mm;
  logic [3:0]  mm_sel, mm_min_sel, mm_max_sel;
  logic        mm_busy, mm_done;
  logic [15:0] mm_rd, mm_min_cnt, mm_max_cnt;

  ro_sweep_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(GMM), .CNT_W(16)) u_mm (
    .static_clk(clk), .rst(rst), .start(mm_start), .abort(1'b0), .osc_in(osc_mm),
    .select3(mm_sel[3]), .select2(mm_sel[2]), .select1(mm_sel[1]), .select0(mm_sel[0]),
    .busy(mm_busy), .done(mm_done), .rd_addr(rd_addr), .rd_data(mm_rd),
    .min_cnt(mm_min_cnt), .max_cnt(mm_max_cnt), .min_sel(mm_min_sel), .max_sel(mm_max_sel)
  );

  initial begin
    osc_mm = 1'b0;
    #3;
    forever begin #(5 * (2 + int'(mm_sel))); osc_mm = ~osc_mm; end
  end
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic read_bank(input int which);
    exp_t e;
    int   got;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      sb_q.push_back('{a, exp_lo[a], exp_hi[a], which});
      @(posedge clk); #1;
      e   = sb_q.pop_front();
      got = 0;
      case (e.which)
        0: got = int'(m_rd);
        1: got = int'(s_rd);
`ifdef RO_SWEEP_MINMAX_EN
        2: got = int'(mm_rd);
`endif
        default: got = -1;
      endcase
      n_cmp++;
      if (got < e.lo || got > e.hi) begin
        n_err++;
        $display("FAIL bank_read dut%0d addr=%0d got=%0d expected=[%0d..%0d]",
                 e.which, e.addr, got, e.lo, e.hi);
      end
    end
  endtask

  task automatic set_exp(input int lo_a, input int hi_a, input int lo_b, input int hi_b,
                         input int split);
    for (int a = 0; a < 16; a++) begin
      exp_lo[a] = (a < split) ? lo_a : lo_b;
      exp_hi[a] = (a < split) ? hi_a : hi_b;
    end
  endtask

  // Pulses start, then follows the main DUT until busy drops (bounded).
  task automatic run_sweep(input bit poke, output int busy_cyc, output int done_cnt);
    int prev;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    prev     = -1;
    sel_q.delete();
    for (int c = 0; c < 4000; c++) begin
      if (!m_busy) break;
      busy_cyc++;
      if (m_done) done_cnt++;
      if (int'(m_sel) != prev) begin
        sel_q.push_back(int'(m_sel));
        prev = int'(m_sel);
      end
      start = poke && (busy_cyc >= 100) && (busy_cyc < 200);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (m_busy) begin
      n_cmp++; n_err++;
      $display("FAIL sweep_timeout busy=%0b required=0", m_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", m_busy); end
    n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", m_done); end
    n_cmp++; if (m_sel !== 4'd0) begin n_err++; $display("FAIL reset_select got=%0d exp=0", m_sel); end
    rst = 1'b0;
    @(posedge clk); #1;
    set_exp(0, 0, 0, 0, 16);
    read_bank(0);
  endtask

  task automatic test_sweep();
    int bc, dc;
    bit seq_ok;
    osc_half_main = 20;
    run_sweep(1'b0, bc, dc);
    n_cmp++; if (bc !== SWEEP_LEN) begin n_err++; $display("FAIL sweep_busy_len got=%0d exp=%0d", bc, SWEEP_LEN); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL sweep_done_pulses got=%0d exp=1", dc); end
    seq_ok = (sel_q.size() == 16);
    if (seq_ok) for (int i = 0; i < 16; i++) if (sel_q[i] != i) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL sweep_select_seq got_len=%0d exp=0..15", sel_q.size()); end
    set_exp(24, 26, 24, 26, 16);
    read_bank(0);
    set_exp(15, 15, 15, 15, 16);
    read_bank(1);
  endtask

  task automatic test_start_while_busy();
    int bc, dc;
    run_sweep(1'b1, bc, dc);
    n_cmp++; if (bc !== SWEEP_LEN) begin n_err++; $display("FAIL busy_start_len got=%0d exp=%0d", bc, SWEEP_LEN); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL busy_start_done got=%0d exp=1", dc); end
    @(posedge clk); #1;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL busy_start_restart got=%0b exp=0", m_busy); end
  endtask

  task automatic test_reset_mid();
    rd_addr = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (800) @(posedge clk);
    #1;
    n_cmp++; if (m_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_busy got=%0b exp=1", m_busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%0b exp=0", m_busy); end
    n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%0b exp=0", m_done); end
    n_cmp++; if (m_sel !== 4'd0) begin n_err++; $display("FAIL rstmid_select got=%0d exp=0", m_sel); end
    n_cmp++; if (m_rd !== 16'd0) begin n_err++; $display("FAIL rstmid_rd_data got=%0d exp=0", m_rd); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_exp(0, 0, 0, 0, 16);
    read_bank(0);
  endtask

  task automatic test_abort();
    int dc;
    bit found;
    osc_half_main = 40;
    dc    = 0;
    found = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (m_done) dc++;
      if (m_sel == 4'd5) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL abort_reach_sel5 got_sel=%0d exp=5", m_sel); end
    repeat (10) begin
      @(posedge clk); #1;
      if (m_done) dc++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%0b exp=0", m_busy); end
    n_cmp++; if (m_sel !== 4'd0) begin n_err++; $display("FAIL abort_select got=%0d exp=0", m_sel); end
    repeat (5) begin
      if (m_done) dc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", dc); end
    set_exp(11, 14, 0, 0, 5);
    read_bank(0);
  endtask

  task automatic test_start_abort_idle();
    int bc;
    bc    = 0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) begin
      if (m_busy) bc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL start_abort_idle busy_cycles=%0d exp=0", bc); end
  endtask

`ifdef RO_SWEEP_MINMAX_EN
  task automatic test_minmax();
    bit fin;
    fin = 1'b0;
    mm_start = 1'b1;
    @(posedge clk); #1;
    mm_start = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (mm_done) begin fin = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!fin) begin n_err++; $display("FAIL mm_timeout done=%0b exp=1", mm_done); end
    n_cmp++; if (mm_max_sel !== 4'd0) begin n_err++; $display("FAIL mm_max_sel got=%0d exp=0", mm_max_sel); end
    n_cmp++; if (mm_min_sel !== 4'd15) begin n_err++; $display("FAIL mm_min_sel got=%0d exp=15", mm_min_sel); end
    n_cmp++;
    if (int'(mm_max_cnt) < 999 || int'(mm_max_cnt) > 1001) begin
      n_err++; $display("FAIL mm_max_cnt got=%0d exp=[999..1001]", mm_max_cnt);
    end
    n_cmp++;
    if (int'(mm_min_cnt) < 116 || int'(mm_min_cnt) > 119) begin
      n_err++; $display("FAIL mm_min_cnt got=%0d exp=[116..119]", mm_min_cnt);
    end
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      exp_lo[a] = int'(GMM) / (2 + a) - 1;
      exp_hi[a] = int'(GMM) / (2 + a) + 1;
    end
    read_bank(2);
  endtask
`endif

  initial begin
    osc_half_main = 20;
`ifdef RO_SWEEP_MINMAX_EN
    mm_start = 1'b0;
`endif
    test_reset();
    test_sweep();
    test_start_while_busy();
    test_reset_mid();
    test_abort();
    test_start_abort_idle();
`ifdef RO_SWEEP_MINMAX_EN
    test_minmax();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ro_sweep_ctrl.md
# ro_sweep_ctrl

Sweep controller for the 16-tap ring oscillator. On `start`, it steps the oscillator's 4-bit tap select through all 16 settings. At each setting it waits for the oscillator to settle, then counts oscillator rising edges over a fixed gate window of `static_clk` cycles. It stores one count per setting in an internal result bank that software reads back through a synchronous read port. It sits between the host/test logic and the oscillator's `select3..select0` / `osc_out` pins, in the `static_clk` domain.

## Interface
- `SETTLE_CYCLES`, 16: `static_clk` cycles to wait after each select change before counting (≥1).
- `GATE_CYCLES`, 1024: length of the counting window in `static_clk` cycles (≥1).
- `CNT_W`, 16: width of each edge count and of `rd_data`.
- `static_clk` in 1: only clock.
- `rst` in 1: reset, asynchronous, active-high; clears all state.
- `start` in 1: level-sampled in IDLE; starts a sweep.
- `abort` in 1: terminates a sweep in progress.
- `osc_in` in 1: oscillator output, asynchronous to `static_clk`.
- `select3`, `select2`, `select1`, `select0` out 1 each: tap select to the oscillator, MSB first.
- `busy` out 1: high from the first cycle after an accepted `start` until the sweep ends.
- `done` out 1: one-cycle pulse when a full sweep completes.
- `rd_addr` in 4: result bank read address.
- `rd_data` out `CNT_W`: result for `rd_addr`, registered.

## Operation
- `osc_in` passes through a 2-flop synchronizer, then a third flop. A rising edge is `sync & ~prev`.
- The measurable oscillator frequency must be < `static_clk`/2. Faster oscillators alias; the block does not detect this.
- State machine: IDLE, SETTLE, MEASURE, STORE, DONE.
- IDLE: `busy`=0. `sel`=0 on outputs.
  - `start`=1 → SETTLE with `sel`=0 and the timer loaded to `SETTLE_CYCLES`-1.
- SETTLE: timer counts down. At 0 → MEASURE; the edge counter clears and the timer loads `GATE_CYCLES`-1.
- MEASURE: the edge counter increments on each detected edge and saturates at 2^`CNT_W`-1 with no wrap. When the timer reaches 0 → STORE.
  - The edge in the final MEASURE cycle is counted.
- STORE, one cycle:
  - Write the count to `bank[sel]`.
  - If `sel`=15 → DONE.
  - Otherwise increment `sel` and go to SETTLE.
- DONE, one cycle: `done`=1, `busy` stays 1 this cycle, `sel` returns to 0 → IDLE.
- `abort`=1 in any non-IDLE state → IDLE next cycle, with no `done`. `bank` entries already written are kept; the entry for the current `sel` is not written.
  - `abort` has priority over every transition, including the STORE write.
  - `abort` in IDLE is ignored.
  - `start` and `abort` both high in IDLE: `abort` wins, and the sweep does not start.
- `start` is ignored while `busy`. Holding `start` high after a sweep completes starts a new sweep on the first IDLE cycle.
- Read port: `rd_data` <= `bank[rd_addr]` every cycle. A read of an entry being written in the same cycle returns the old value.
- Reset values:
  - `select3..0`=0, `busy`=0, `done`=0, `rd_data`=0.
  - All `bank` entries are 0, and the synchronizer flops, timer and counters are 0.
  - State is IDLE.
- Reset mid-sweep: immediate return to all reset values, and the bank is cleared.

## Timing
- `start` high in IDLE at edge N: `busy`=1 and SETTLE from edge N+1.
- Per setting: `SETTLE_CYCLES` + `GATE_CYCLES` + 1 (STORE) cycles.
- Full sweep: `busy` high for 16·(`SETTLE_CYCLES`+`GATE_CYCLES`+1)+1 cycles. `done` is high in the last of them.
- Select outputs are registered and change on the edge that enters SETTLE. They are stable for the whole of SETTLE and MEASURE.
- Synchronizer latency is 2 cycles. Edges arriving in the last 2 SETTLE cycles may be counted in MEASURE; this is accepted as part of the settle margin.
- `rd_data` latency: 1 cycle from `rd_addr`.

## Configuration
- `RO_SWEEP_MINMAX_EN` defined adds the following outputs:
  - `min_cnt` [`CNT_W`], `max_cnt` [`CNT_W`], `min_sel` [4], `max_sel` [4].
  - They update in each STORE cycle by strict comparison, so on ties the first (lowest) `sel` is kept.
  - At the first STORE of a sweep both min and max are loaded unconditionally.
  - Reset value: all 0. The values are valid from the DONE cycle and hold until the next sweep's first STORE.
  - Abort leaves them at their partial values.
- `RO_SWEEP_MINMAX_EN` undefined: the ports and logic are absent, and all other behaviour is identical.

## Test plan
- Reset then idle: `busy`=0, `done`=0, `select`=0000, `rd_data`=0 for all 16 addresses.
- Setup: `SETTLE_CYCLES`=4, `GATE_CYCLES`=100, `osc_in` is a square wave with period 4 cycles. Pulse `start` → `busy` for 16·105+1 = 1681 cycles; one `done` pulse; `select` steps 0..15; every `bank` entry = 25 ±1.
- Saturation: `CNT_W`=4, `osc_in` period 2 cycles, `GATE_CYCLES`=100 → every entry = 15.
- Abort: assert `abort` during MEASURE at `sel`=5 → `busy`=0 next cycle; no `done`; entries 0..4 written; 5..15 unchanged from before.
- `start` while `busy` is ignored (sweep length unchanged). `start`+`abort` in IDLE → no sweep. `rst` mid-sweep → all outputs 0 and bank cleared.
- With `RO_SWEEP_MINMAX_EN`: `osc_in` period varies by `sel` (period = 2+`sel`) → `max_sel`=0, `min_sel`=15, and `max_cnt`/`min_cnt` match the bank entries.
